kmeans_vector_distance: RTL

//  Parametrised successor to the scalar distance unit: streams DIM coordinate

---
 rtl/kmeans_vector_distance_if.sv | 26 ++
 rtl/kmeans_vector_distance.sv | 136 +++++++++++++
 2 files changed

// File: rtl/kmeans_vector_distance_if.sv
// Handshake bundle for the vector distance unit: coordinate-pair input stream
// and distance result output stream.
interface kmeans_vector_distance_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM    = 4,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(DIM + 1)
);
  logic              vdist_in_valid;
  logic              vdist_in_ready;
  logic [DATA_W-1:0] vdist_a;
  logic [DATA_W-1:0] vdist_b;
  logic              vdist_mode;
  logic              vdist_out_valid;
  logic              vdist_out_ready;
  logic [ACC_W-1:0]  vdist_out;

  modport slave (
    input  vdist_in_valid, vdist_a, vdist_b, vdist_mode, vdist_out_ready,
    output vdist_in_ready, vdist_out_valid, vdist_out
  );

  modport master (
    output vdist_in_valid, vdist_a, vdist_b, vdist_mode, vdist_out_ready,
    input  vdist_in_ready, vdist_out_valid, vdist_out
  );
endinterface

// File: rtl/kmeans_vector_distance.sv
// Streams DIM coordinate pairs and returns one squared-Euclidean or Manhattan
// distance per vector through a three-stage pipeline, one vector in flight.
module kmeans_vector_distance #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM    = 4,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(DIM + 1)
) (
  input  logic                     vdist_clk,
  input  logic                     vdist_rst,
  kmeans_vector_distance_if.slave  bus
);

  localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_BUSY   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [IDX_W-1:0]    r_idx;
  logic                r_mode;
  logic                r_s1_valid;
  logic                r_s1_first;
  logic                r_s1_last;
  logic                r_s1_mode;
  logic [DATA_W-1:0]   r_s1_d;
  logic                r_s2_valid;
  logic                r_s2_first;
  logic                r_s2_last;
  logic [2*DATA_W-1:0] r_s2_term;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_out;
  logic                r_out_valid;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_first;
  logic                w_last;
  logic                w_mode_eff;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_d_ext;
  logic [2*DATA_W-1:0] w_square;
  logic [2*DATA_W-1:0] w_term;
  logic [ACC_W-1:0]    w_term_ext;
  logic [ACC_W-1:0]    w_sum;

  assign w_in_ready = (r_state == ST_ACCEPT);
  assign w_accept   = bus.vdist_in_valid & w_in_ready;
  assign w_first    = (r_idx == '0);
  assign w_last     = (r_idx == LAST_IDX);
  // Mode is taken live on the first pair and from the latch for the rest.
  assign w_mode_eff = w_first ? bus.vdist_mode : r_mode;
  assign w_diff     = (bus.vdist_a >= bus.vdist_b) ? (bus.vdist_a - bus.vdist_b)
                                                   : (bus.vdist_b - bus.vdist_a);

  assign w_d_ext    = {{DATA_W{1'b0}}, r_s1_d};
  assign w_square   = w_d_ext * w_d_ext;
  assign w_term     = r_s1_mode ? w_d_ext : w_square;

  assign w_term_ext = {{(ACC_W - 2*DATA_W){1'b0}}, r_s2_term};
  assign w_sum      = (r_s2_first ? '0 : r_acc) + w_term_ext;

  assign bus.vdist_in_ready  = w_in_ready;
  assign bus.vdist_out_valid = r_out_valid;
  assign bus.vdist_out       = r_out;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCEPT: if (w_accept && w_last) w_state_next = ST_BUSY;
      ST_BUSY:   if (r_out_valid && bus.vdist_out_ready) w_state_next = ST_ACCEPT;
      default:   w_state_next = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge vdist_clk) begin
    if (vdist_rst) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge vdist_clk) begin
    if (vdist_rst) begin
      r_idx       <= '0;
      r_mode      <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_d      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_term   <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_idx      <= w_last ? '0 : r_idx + 1'b1;
        r_mode     <= w_mode_eff;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_mode  <= w_mode_eff;
        r_s1_d     <= w_diff;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_term  <= w_term;
      end

      // Only one vector is ever in flight, so a handshake never races a new result.
      if (r_out_valid && bus.vdist_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_s2_valid) begin
        r_acc <= w_sum;
        if (r_s2_last) begin
          r_out       <= w_sum;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
